// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between requester A
//   (ALU/execute writeback) and requester B (load/memory writeback).
//   Each requester is buffered in a DEPTH-entry FIFO; at most one RF write
//   issues per cycle. Writes to x0 are dropped at the source. An ECALL
//   drains all pending writes, then raises a sticky halt.
//
//   Configuration macro: RF_ARB_FIXED_PRIO_EN
//     defined   : A has strict priority over B when both FIFOs hold entries
//     undefined : round-robin between A and B (A wins the first tie)
//
//   Ports
//     clk, reset          clock; asynchronous active-low reset
//     a_valid/a_ready     requester A handshake, a_rd/a_data payload
//     b_valid/b_ready     requester B handshake, b_rd/b_data payload
//     is_ecall            level-sampled ECALL request (honoured in RUN only)
//     rf_write_enable     register file write strobe
//     rf_rd/rf_din        register file write index/data (0 when idle)
//     busy                any FIFO non-empty, or draining
//     halted              sticky, set once the drain completes
//
// state  | meaning
// RUN    | accepting writes from A and B, issuing to the RF
// DRAIN  | ECALL seen; no new accepts, issuing until both FIFOs empty
// HALTED | drain done; halted=1 until reset

module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              is_ecall,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_din,
  output logic              busy,
  output logic              halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;

  logic [ADDR_W-1:0] a_rd_mem   [DEPTH];
  logic [DATA_W-1:0] a_data_mem [DEPTH];
  logic [ADDR_W-1:0] b_rd_mem   [DEPTH];
  logic [DATA_W-1:0] b_data_mem [DEPTH];
  logic [PW-1:0]     a_wp, a_rp, b_wp, b_rp;
  logic [CW-1:0]     a_cnt, b_cnt;

  logic a_full, b_full, a_empty, b_empty;
  logic push_a, push_b, gnt_a, gnt_b;
`ifndef RF_ARB_FIXED_PRIO_EN
  logic last_grant_a;   // 1 = A took the last grant; reset favours A on the first tie
`endif

  assign a_full  = (a_cnt == CW'(DEPTH));
  assign b_full  = (b_cnt == CW'(DEPTH));
  assign a_empty = (a_cnt == '0);
  assign b_empty = (b_cnt == '0);

  // reset is folded in so ready reads 0 while the block is held in reset
  assign a_ready = reset && (state == RUN) && !a_full;
  assign b_ready = reset && (state == RUN) && !b_full;

  // x0 writes complete the handshake but are never stored
  assign push_a = a_valid && a_ready && (a_rd != '0);
  assign push_b = b_valid && b_ready && (b_rd != '0);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!a_empty && !b_empty) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      gnt_a = 1'b1;
`else
      gnt_a = !last_grant_a;
      gnt_b = last_grant_a;
`endif
    end else if (!a_empty) begin
      gnt_a = 1'b1;
    end else if (!b_empty) begin
      gnt_b = 1'b1;
    end
  end

  assign rf_write_enable = gnt_a || gnt_b;
  assign rf_rd  = gnt_a ? a_rd_mem[a_rp]   : (gnt_b ? b_rd_mem[b_rp]   : '0);
  assign rf_din = gnt_a ? a_data_mem[a_rp] : (gnt_b ? b_data_mem[b_rp] : '0);
  assign busy   = !a_empty || !b_empty || (state == DRAIN);

  // storage needs no reset: counts gate every read
  always_ff @(posedge clk) begin
    if (push_a) begin
      a_rd_mem[a_wp]   <= a_rd;
      a_data_mem[a_wp] <= a_data;
    end
    if (push_b) begin
      b_rd_mem[b_wp]   <= b_rd;
      b_data_mem[b_wp] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wp  <= '0;
      a_rp  <= '0;
      a_cnt <= '0;
      b_wp  <= '0;
      b_rp  <= '0;
      b_cnt <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_grant_a <= 1'b0;
`endif
    end else begin
      if (push_a) a_wp <= a_wp + PW'(1);
      if (gnt_a)  a_rp <= a_rp + PW'(1);
      if (push_b) b_wp <= b_wp + PW'(1);
      if (gnt_b)  b_rp <= b_rp + PW'(1);
      case ({push_a, gnt_a})
        2'b10:   a_cnt <= a_cnt + CW'(1);
        2'b01:   a_cnt <= a_cnt - CW'(1);
        default: a_cnt <= a_cnt;
      endcase
      case ({push_b, gnt_b})
        2'b10:   b_cnt <= b_cnt + CW'(1);
        2'b01:   b_cnt <= b_cnt - CW'(1);
        default: b_cnt <= b_cnt;
      endcase
`ifndef RF_ARB_FIXED_PRIO_EN
      if (gnt_a || gnt_b) last_grant_a <= gnt_a;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN:     if (is_ecall) state <= DRAIN;
        DRAIN:   if (a_empty && b_empty) begin
                   state  <= HALTED;
                   halted <= 1'b1;
                 end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
